// File: rtl/pixel_pkg.sv
// pixel_pkg: shared flag bit positions and width helpers for the pixel stream buffer
package pixel_pkg;
  localparam int IRQ_LOW_BIT  = 0;
  localparam int IRQ_HIGH_BIT = 1;
  localparam int IRQ_OVF_BIT  = 2;
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int coord_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pixel_ram.sv
// pixel_ram: simple dual-port DEPTH x W storage, synchronous write and asynchronous read
module pixel_ram
  import pixel_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 1280,
  parameter int AW    = coord_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/pixel_stream_buffer.sv
// pixel_stream_buffer: first-word fall-through pixel FIFO with raster coordinates and watermark/overflow flags
module pixel_stream_buffer
  import pixel_pkg::*;
#(
  parameter int PIXEL_W     = 24,
  parameter int DEPTH       = 1280,
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [PIXEL_W-1:0]              wr_pixel,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [PIXEL_W-1:0]              rd_pixel,
  output logic [coord_w(LINE_PIXELS)-1:0] rd_x,
  output logic [coord_w(FRAME_LINES)-1:0] rd_y,
  output logic                            rd_eol,
  output logic                            rd_eof,
  output logic [lvl_w(DEPTH)-1:0]         level,
  input  logic [lvl_w(DEPTH)-1:0]         low_wm,
  input  logic [lvl_w(DEPTH)-1:0]         high_wm,
  output logic                            irq_low,
  output logic                            irq_high,
  output logic                            ovf_err,
  input  logic [2:0]                      irq_clr
);
  localparam int AW = coord_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam int XW = coord_w(LINE_PIXELS);
  localparam int YW = coord_w(FRAME_LINES);
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [2:0]         flag_q, flag_d, flag_set;
  logic               full, wr_fire, rd_fire;
  logic [PIXEL_W-1:0] ram_rdata;
  assign full     = level_q == LW'(DEPTH);
  assign wr_ready = !full;
  assign rd_valid = level_q != '0;
  assign rd_fire  = rd_valid && rd_ready && !flush;
  assign wr_fire  = wr_valid && (!full || rd_fire) && !flush;
  assign rd_eol   = x_q == XW'(LINE_PIXELS - 1);
  assign rd_eof   = rd_eol && y_q == YW'(FRAME_LINES - 1);
  assign flag_set[IRQ_LOW_BIT]  = level_q > low_wm && level_d <= low_wm;
  assign flag_set[IRQ_HIGH_BIT] = level_q < high_wm && level_d >= high_wm;
  assign flag_set[IRQ_OVF_BIT]  = wr_valid && !wr_fire && !flush;
  always_comb begin
    wr_ptr_d = flush ? '0 : !wr_fire ? wr_ptr_q : wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + AW'(1);
    rd_ptr_d = flush ? '0 : !rd_fire ? rd_ptr_q : rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + AW'(1);
    level_d  = flush ? '0 : level_q + LW'(wr_fire) - LW'(rd_fire);
    x_d      = flush ? '0 : !rd_fire ? x_q : rd_eol ? '0 : x_q + XW'(1);
    y_d      = flush ? '0 : !(rd_fire && rd_eol) ? y_q : rd_eof ? '0 : y_q + YW'(1);
    flag_d   = flag_set | (flag_q & ~irq_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      flag_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      x_q      <= x_d;
      y_q      <= y_d;
      flag_q   <= flag_d;
    end
  end
  pixel_ram #(.W(PIXEL_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr_q),
    .wdata (wr_pixel),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );
  assign rd_pixel = rd_valid ? ram_rdata : '0;
  assign level    = level_q;
  assign rd_x     = x_q;
  assign rd_y     = y_q;
  assign irq_low  = flag_q[IRQ_LOW_BIT];
  assign irq_high = flag_q[IRQ_HIGH_BIT];
  assign ovf_err  = flag_q[IRQ_OVF_BIT];
endmodule

// File: tb/tb_pixel_stream_buffer.sv
// tb_pixel_stream_buffer: scoreboard bench driving DEPTH=8 and DEPTH=5 buffers with shared stimulus
module tb_pixel_stream_buffer;
  logic clk = 0, rst = 1, flush = 0, wr_valid = 0, rd_ready = 0;
  logic [23:0] wr_pixel = '0;
  logic [3:0] low_wm = 4'd2, high_wm = 4'd6;
  logic [2:0] irq_clr = '0;
  logic wr8, rv8, eol8, eof8, il8, ih8, ov8, y8;
  logic wr5, rv5, eol5, eof5, il5, ih5, ov5, y5;
  logic [23:0] px8, px5;
  logic [1:0] x8, x5;
  logic [3:0] lv8;
  logic [2:0] lv5;
  int checks = 0, failures = 0;
  int ml[2], ri[2], rc[2];
  bit fl[2], fh[2], fo[2], was_rst;
  logic [23:0] exp0[$], exp1[$];
  always #5 clk = ~clk;
  pixel_stream_buffer #(.PIXEL_W(24), .DEPTH(8), .LINE_PIXELS(4), .FRAME_LINES(2)) u8 (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr8), .wr_pixel(wr_pixel),
    .rd_valid(rv8), .rd_ready(rd_ready), .rd_pixel(px8), .rd_x(x8), .rd_y(y8), .rd_eol(eol8), .rd_eof(eof8),
    .level(lv8), .low_wm(low_wm), .high_wm(high_wm), .irq_low(il8), .irq_high(ih8), .ovf_err(ov8), .irq_clr(irq_clr)
  );
  pixel_stream_buffer #(.PIXEL_W(24), .DEPTH(5), .LINE_PIXELS(4), .FRAME_LINES(2)) u5 (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr5), .wr_pixel(wr_pixel),
    .rd_valid(rv5), .rd_ready(rd_ready), .rd_pixel(px5), .rd_x(x5), .rd_y(y5), .rd_eol(eol5), .rd_eof(eof5),
    .level(lv5), .low_wm(low_wm[2:0]), .high_wm(high_wm[2:0]), .irq_low(il5), .irq_high(ih5), .ovf_err(ov5), .irq_clr(irq_clr)
  );
  task automatic model_step(input int i, input int d);
    int rf, wf, nl;
    rf = (ml[i] > 0 && rd_ready) ? 1 : 0;
    wf = (wr_valid && (ml[i] < d || rf == 1)) ? 1 : 0;
    nl = flush ? 0 : ml[i] + wf - rf;
    if (!flush && wf == 1) begin
      if (i == 0) exp0.push_back(wr_pixel);
      else exp1.push_back(wr_pixel);
    end
    fl[i] = (ml[i] > int'(low_wm) && nl <= int'(low_wm)) || (fl[i] && !irq_clr[0]);
    fh[i] = (ml[i] < int'(high_wm) && nl >= int'(high_wm)) || (fh[i] && !irq_clr[1]);
    fo[i] = (!flush && wr_valid && wf == 0) || (fo[i] && !irq_clr[2]);
    ml[i] = nl;
  endtask
  always @(posedge clk) begin
    was_rst = rst;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ml[i] = 0;
        fl[i] = 0;
        fh[i] = 0;
        fo[i] = 0;
      end
    end else begin
      model_step(0, 8);
      model_step(1, 5);
    end
  end
  task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", n, i, a, e, $time);
    end
  endtask
  task automatic mon(input int i, input int d, input logic rv, input logic wrdy, input logic [3:0] lv,
                     input logic [23:0] px, input logic [1:0] x, input logic y, input logic eol,
                     input logic eof, input logic il, input logic ih, input logic ov);
    int qs, ex, ey;
    qs = (i == 0) ? exp0.size() : exp1.size();
    ex = rc[i] % 4;
    ey = (rc[i] / 4) % 2;
    chk("level", i, lv, ml[i]);
    chk("rd_valid", i, rv, ml[i] != 0);
    chk("wr_ready", i, wrdy, ml[i] != d);
    chk("irq_low", i, il, fl[i]);
    chk("irq_high", i, ih, fh[i]);
    chk("ovf_err", i, ov, fo[i]);
    chk("rd_x", i, x, ex);
    chk("rd_y", i, y, ey);
    chk("rd_eol", i, eol, ex == 3);
    chk("rd_eof", i, eof, ex == 3 && ey == 1);
    if (was_rst) chk("rd_pixel_reset", i, px, 0);
    if (rv && rd_ready && !flush && !rst) begin
      if (ri[i] < qs) chk("rd_pixel", i, px, (i == 0) ? exp0[ri[i]] : exp1[ri[i]]);
      else begin
        checks++;
        failures++;
        $display("FAIL rd_underflow inst=%0d actual=%0h required=none t=%0t", i, px, $time);
      end
      ri[i]++;
      rc[i]++;
    end
    if (flush || rst) begin
      ri[i] = qs;
      rc[i] = 0;
    end
  endtask
  always @(negedge clk) begin
    mon(0, 8, rv8, wr8, lv8, px8, x8, y8, eol8, eof8, il8, ih8, ov8);
    mon(1, 5, rv5, wr5, {1'b0, lv5}, px5, x5, y5, eol5, eof5, il5, ih5, ov5);
  end
  task automatic step(input logic wv, input logic [23:0] px, input logic rr,
                      input logic fls = 1'b0, input logic [2:0] clr = 3'b000);
    wr_valid = wv;
    wr_pixel = px;
    rd_ready = rr;
    flush = fls;
    irq_clr = clr;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 0;
    for (int i = 1; i <= 3; i++) step(1, 24'(i), 0);
    step(0, 0, 0);
    repeat (3) step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 24'h100 + 24'(i), 0);
    step(1, 24'hdead, 0);
    step(1, 24'h200, 1);
    step(0, 0, 0);
    repeat (4) step(0, 0, 1);
    step(1, 24'hbad, 1, 1);
    step(0, 0, 0);
    step(0, 0, 0, 0, 3'b111);
    for (int i = 0; i < 3; i++) step(1, 24'h500 + 24'(i), 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    step(0, 0, 0, 0, 3'b001);
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(i < 8, 24'h300 + 24'(i), 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 14; i++) step(i < 12, 24'h400 + 24'(i), i >= 2);
    for (int b = 0; b < 15; b++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      low_wm = 4'($urandom_range(0, 5));
      high_wm = 4'($urandom_range(0, 7));
      for (int c = 0; c < 200; c++) begin
        rst = ($urandom_range(0, 499) == 0);
        step($urandom_range(0, 99) < wp, 24'($urandom), $urandom_range(0, 99) < rp,
             $urandom_range(0, 127) == 0, ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000);
      end
    end
    rst = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
